// File: rtl/dq_out_serializer_if.sv
// dq_out_serializer_if: write-word handshake and DQ output bundle for dq_out_serializer
interface dq_out_serializer_if #(
  parameter int DATA_WIDTH = 8,
  parameter int BEATS = 4
);
  logic [DATA_WIDTH*BEATS-1:0] wr_data;
  logic wr_valid;
  logic wr_ready;
  logic ddr_mode;
  logic [DATA_WIDTH-1:0] dq_rise;
  logic [DATA_WIDTH-1:0] dq_fall;
  logic dq_oe;
  logic busy;
  modport master (
    output wr_data, wr_valid, ddr_mode,
    input wr_ready, dq_rise, dq_fall, dq_oe, busy
  );
  modport slave (
    input wr_data, wr_valid, ddr_mode,
    output wr_ready, dq_rise, dq_fall, dq_oe, busy
  );
endinterface

// File: rtl/dq_out_serializer.sv
// dq_out_serializer: FIFO-buffered SDR/DDR DQ serializer, one beat pair per cycle; DQ_SER_POSTAMBLE_EN adds a one-cycle postamble
module dq_out_serializer #(
  parameter int DATA_WIDTH = 8,
  parameter int BEATS = 4,
  parameter int FIFO_DEPTH = 4
) (
  input logic clk,
  input logic reset_n,
  dq_out_serializer_if.slave bus
);
  localparam int WW = DATA_WIDTH * BEATS;
  localparam int CW = $clog2(BEATS);
  localparam int AW = $clog2(FIFO_DEPTH);
  typedef enum logic [1:0] {IDLE, DRIVE, POST} state_t;
  state_t state_q, state_d;
  logic [WW-1:0] mem_q [FIFO_DEPTH];
  logic [WW-1:0] mem_d [FIFO_DEPTH];
  logic [AW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [AW:0] count_q, count_d;
  logic [WW-1:0] sh_q, sh_d, head;
  logic mode_q, mode_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [DATA_WIDTH-1:0] rise_q, rise_d, fall_q, fall_d;
  logic oe_q, oe_d;
  logic push, pop, nonempty, last;
  assign nonempty = count_q != '0;
  assign bus.wr_ready = count_q != (AW+1)'(FIFO_DEPTH);
  assign push = bus.wr_valid & bus.wr_ready;
  assign head = mem_q[rd_ptr_q];
  assign last = cnt_q == (mode_q ? CW'(BEATS/2 - 1) : CW'(BEATS - 1));
  assign pop = nonempty & ((state_q != DRIVE) | last);
  assign bus.dq_rise = rise_q;
  assign bus.dq_fall = fall_q;
  assign bus.dq_oe = oe_q;
  assign bus.busy = oe_q | nonempty;
  always_comb begin
    mem_d = mem_q;
    if (push) mem_d[wr_ptr_q] = bus.wr_data;
    wr_ptr_d = wr_ptr_q + AW'(push);
    rd_ptr_d = rd_ptr_q + AW'(pop);
    count_d = count_q + (AW+1)'(push) - (AW+1)'(pop);
    state_d = state_q;
    sh_d = sh_q;
    mode_d = mode_q;
    cnt_d = cnt_q;
    rise_d = '0;
    fall_d = '0;
    oe_d = 1'b0;
    if (pop) begin
      state_d = DRIVE;
      mode_d = bus.ddr_mode;
      cnt_d = '0;
      sh_d = bus.ddr_mode ? head >> (2*DATA_WIDTH) : head >> DATA_WIDTH;
      rise_d = head[DATA_WIDTH-1:0];
      fall_d = bus.ddr_mode ? head[2*DATA_WIDTH-1:DATA_WIDTH] : head[DATA_WIDTH-1:0];
      oe_d = 1'b1;
    end else if (state_q == DRIVE && !last) begin
      cnt_d = cnt_q + CW'(1);
      sh_d = mode_q ? sh_q >> (2*DATA_WIDTH) : sh_q >> DATA_WIDTH;
      rise_d = sh_q[DATA_WIDTH-1:0];
      fall_d = mode_q ? sh_q[2*DATA_WIDTH-1:DATA_WIDTH] : sh_q[DATA_WIDTH-1:0];
      oe_d = 1'b1;
    end else if (state_q == DRIVE) begin
`ifdef DQ_SER_POSTAMBLE_EN
      state_d = POST;
      rise_d = fall_q;
      fall_d = fall_q;
      oe_d = 1'b1;
`else
      state_d = IDLE;
`endif
    end else begin
      state_d = IDLE;
    end
  end
  always_ff @(posedge clk) begin
    mem_q <= mem_d;
  end
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q <= IDLE;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q <= '0;
      sh_q <= '0;
      mode_q <= 1'b0;
      cnt_q <= '0;
      rise_q <= '0;
      fall_q <= '0;
      oe_q <= 1'b0;
    end else begin
      state_q <= state_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q <= count_d;
      sh_q <= sh_d;
      mode_q <= mode_d;
      cnt_q <= cnt_d;
      rise_q <= rise_d;
      fall_q <= fall_d;
      oe_q <= oe_d;
    end
  end
endmodule
